// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: round-robin sharing of one ALU between two requesters with a response handshake
module alu_arbiter_seq #(
  parameter int WIDTH = 8,
  parameter int OPW = 5,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_choice,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, id_q, id_d, rv_q, rv_d, gnt, idle;
  logic [3:0] cnt_q, cnt_d, flags_q, flags_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0] op_q, op_d;
  assign idle = rst_n && state_q == IDLE;
  assign gnt = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign req0_ready = idle && req0_valid && !gnt;
  assign req1_ready = idle && req1_valid && gnt;
  assign busy = rst_n && state_q != IDLE;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_choice = op_q;
  assign resp_valid = rv_q;
  assign resp_id = id_q;
  assign resp_result = res_q;
  assign resp_flags = flags_q;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    rv_d = rv_q;
    cnt_d = cnt_q;
    flags_d = flags_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    op_d = op_q;
    if (req0_ready || req1_ready) begin
      state_d = EXEC;
      id_d = gnt;
      rr_d = !gnt;
      a_d = gnt ? req1_a : req0_a;
      b_d = gnt ? req1_b : req0_b;
      op_d = gnt ? req1_op : req0_op;
      cnt_d = 4'(ALU_LAT - 1);
    end
    if (state_q == EXEC) begin
      cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        state_d = RESP;
        rv_d = 1'b1;
        res_d = alu_result;
        flags_d = {alu_carry, alu_overflow, alu_negative, alu_zero};
      end
    end
    if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
      rv_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      id_q <= 1'b0;
      rv_q <= 1'b0;
      cnt_q <= '0;
      flags_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      rv_q <= rv_d;
      cnt_q <= cnt_d;
      flags_q <= flags_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      op_q <= op_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: vector table, corner sequences and random traffic against a transaction model
module tb_alu_arbiter_seq;
  localparam int LAT = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req0_valid, req1_valid, resp_ready;
  logic [4:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic d1_req0_ready, d1_req1_ready, d1_resp_valid, d1_resp_id, d1_busy;
  logic d1_alu_carry, d1_alu_zero, d1_alu_negative, d1_alu_overflow;
  logic [7:0] d1_alu_a, d1_alu_b, d1_alu_result, d1_resp_result;
  logic [4:0] d1_alu_choice;
  logic [3:0] d1_resp_flags;
  logic t3_req0_ready, t3_req1_ready, t3_resp_valid, t3_resp_id, t3_busy;
  logic t3_alu_carry, t3_alu_zero, t3_alu_negative, t3_alu_overflow;
  logic [7:0] t3_alu_a, t3_alu_b, t3_alu_result, t3_resp_result;
  logic [4:0] t3_alu_choice;
  logic [3:0] t3_resp_flags;
  int checks = 0, failures = 0;

  function automatic logic [11:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic v;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
      5'd1: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
      5'd2: begin s = {a == 8'd0, a - 8'd1}; v = a == 8'd0; end
      default: begin s = {op[0], a ^ b ^ {3'b000, op}}; v = op[1]; end
    endcase
    return {s[8], v, s[7], s[7:0] == 8'd0, s[7:0]};
  endfunction

  assign {d1_alu_carry, d1_alu_overflow, d1_alu_negative, d1_alu_zero, d1_alu_result} = alu_f(d1_alu_choice, d1_alu_a, d1_alu_b);
  assign {t3_alu_carry, t3_alu_overflow, t3_alu_negative, t3_alu_zero, t3_alu_result} = alu_f(t3_alu_choice, t3_alu_a, t3_alu_b);

  alu_arbiter_seq #(.WIDTH(8), .OPW(5), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(d1_req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(d1_req1_ready),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_choice(d1_alu_choice), .alu_result(d1_alu_result),
    .alu_carry(d1_alu_carry), .alu_zero(d1_alu_zero), .alu_negative(d1_alu_negative), .alu_overflow(d1_alu_overflow),
    .resp_valid(d1_resp_valid), .resp_ready(resp_ready), .resp_id(d1_resp_id), .resp_result(d1_resp_result),
    .resp_flags(d1_resp_flags), .busy(d1_busy)
  );

  alu_arbiter_seq #(.WIDTH(8), .OPW(5), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(t3_req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(t3_req1_ready),
    .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_choice(t3_alu_choice), .alu_result(t3_alu_result),
    .alu_carry(t3_alu_carry), .alu_zero(t3_alu_zero), .alu_negative(t3_alu_negative), .alu_overflow(t3_alu_overflow),
    .resp_valid(t3_resp_valid), .resp_ready(resp_ready), .resp_id(t3_resp_id), .resp_result(t3_resp_result),
    .resp_flags(t3_resp_flags), .busy(t3_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    cyc;
    cyc;
    rst_n = 1'b1;
  endtask

  task automatic wait_resp(input string name);
    for (int k = 0; k < 20 && !d1_resp_valid; k++) cyc;
    chk(name, 32'(d1_resp_valid), 32'd1);
  endtask

  int acc_cyc[$];
  logic acc_id[$];

  task automatic run_stream(input logic both);
    do_reset;
    acc_cyc.delete();
    acc_id.delete();
    req0_valid = 1'b1; req0_op = 5'd0; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = both; req1_op = 5'd0; req1_a = 8'h03; req1_b = 8'h04;
    resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (d1_req0_ready || d1_req1_ready) begin
        acc_cyc.push_back(i);
        acc_id.push_back(d1_req1_ready);
      end
      cyc;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  typedef struct {
    logic v0, v1;
    logic [4:0] op;
    logic [7:0] a, b;
    logic r0, r1, id;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;
  vec_t tbl[5];

  logic m_fl, m_ptr, m_id, pr0, pr1, prv, seen;
  int m_wait;
  logic [4:0] m_op;
  logic [7:0] m_a, m_b;
  logic [11:0] m_exp;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5'd0, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0, 8'h80, 4'b0110};
    tbl[1] = '{1'b0, 1'b1, 5'd1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFF, 4'b1010};
    tbl[2] = '{1'b1, 1'b1, 5'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 4'b1001};
    tbl[3] = '{1'b1, 1'b1, 5'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 4'b1110};
    tbl[4] = '{1'b0, 1'b0, 5'd3, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000};
    req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b0;
    cyc;
    cyc;
    #1;
    chk("rst_ready0", 32'(d1_req0_ready), 32'd0);
    chk("rst_ready1", 32'(d1_req1_ready), 32'd0);
    chk("rst_busy", 32'(d1_busy), 32'd0);
    chk("rst_resp_valid", 32'(d1_resp_valid), 32'd0);
    chk("rst_alu", 32'({d1_alu_a, d1_alu_b, d1_alu_choice}), 32'd0);
    chk("rst_resp", 32'({d1_resp_id, d1_resp_result, d1_resp_flags}), 32'd0);
    chk("rst_busy3", 32'(t3_busy), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    cyc;
    resp_ready = 1'b1;
    foreach (tbl[i]) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_op = tbl[i].op; req0_a = tbl[i].a; req0_b = tbl[i].b;
      req1_op = tbl[i].op; req1_a = tbl[i].a; req1_b = tbl[i].b;
      #1;
      chk($sformatf("tbl%0d_ready0", i), 32'(d1_req0_ready), 32'(tbl[i].r0));
      chk($sformatf("tbl%0d_ready1", i), 32'(d1_req1_ready), 32'(tbl[i].r1));
      cyc;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (tbl[i].r0 || tbl[i].r1) begin
        wait_resp($sformatf("tbl%0d_resp_valid", i));
        chk($sformatf("tbl%0d_id", i), 32'(d1_resp_id), 32'(tbl[i].id));
        chk($sformatf("tbl%0d_result", i), 32'(d1_resp_result), 32'(tbl[i].res));
        chk($sformatf("tbl%0d_flags", i), 32'(d1_resp_flags), 32'(tbl[i].fl));
        cyc;
        chk($sformatf("tbl%0d_idle", i), 32'({d1_busy, d1_resp_valid}), 32'd0);
      end
    end
    // response stall
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 5'd0; req0_a = 8'h7F; req0_b = 8'h01;
    cyc;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 5'd1; req1_a = 8'h05; req1_b = 8'h03;
    wait_resp("stall_first_resp");
    for (int i = 0; i < 5; i++) begin
      cyc;
      chk("stall_valid", 32'(d1_resp_valid), 32'd1);
      chk("stall_payload", 32'({d1_resp_id, d1_resp_result, d1_resp_flags}), 32'({1'b0, 8'h80, 4'b0110}));
      chk("stall_ready1", 32'(d1_req1_ready), 32'd0);
      chk("stall_busy", 32'(d1_busy), 32'd1);
    end
    resp_ready = 1'b1;
    cyc;
    chk("stall_release_valid", 32'(d1_resp_valid), 32'd0);
    chk("stall_release_ready1", 32'(d1_req1_ready), 32'd1);
    cyc;
    req1_valid = 1'b0;
    wait_resp("stall_second_resp");
    chk("stall_second_payload", 32'({d1_resp_id, d1_resp_result, d1_resp_flags}), 32'({1'b1, 8'h02, 4'b0000}));
    cyc;
    // back-to-back single requester
    run_stream(1'b0);
    chk("b2b_count", 32'(acc_cyc.size()), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++) chk("b2b_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(LAT + 2));
    // both always valid: grants alternate starting at req0
    run_stream(1'b1);
    chk("rr_count", 32'(acc_cyc.size()), 32'd4);
    for (int i = 0; i < acc_id.size(); i++) chk($sformatf("rr_id%0d", i), 32'(acc_id[i]), 32'(i % 2));
    // ALU_LAT=3 latency
    do_reset;
    req1_valid = 1'b1; req1_op = 5'd2; req1_a = 8'h00; req1_b = 8'h00;
    resp_ready = 1'b1;
    #1;
    chk("lat3_accept", 32'(t3_req1_ready), 32'd1);
    cyc;
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lat3_wait%0d", k), 32'(t3_resp_valid), 32'd0);
      cyc;
    end
    chk("lat3_valid", 32'(t3_resp_valid), 32'd1);
    chk("lat3_payload", 32'({t3_resp_id, t3_resp_result, t3_resp_flags}), 32'({1'b1, 8'hFF, 4'b1110}));
    cyc;
    cyc;
    // reset in EXEC
    do_reset;
    req0_valid = 1'b1; req0_op = 5'd0; req0_a = 8'h7F; req0_b = 8'h01;
    resp_ready = 1'b1;
    cyc;
    req0_valid = 1'b0;
    chk("rexec_busy", 32'(t3_busy), 32'd1);
    rst_n = 1'b0;
    cyc;
    chk("rexec_idle", 32'({t3_busy, t3_resp_valid, d1_resp_valid}), 32'd0);
    chk("rexec_alu", 32'({t3_alu_a, t3_alu_b, t3_alu_choice}), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc;
      seen = seen | t3_resp_valid | d1_resp_valid;
    end
    chk("rexec_no_resp", 32'(seen), 32'd0);
    // random traffic against the transaction model
    do_reset;
    m_fl = 1'b0; m_ptr = 1'b0; m_wait = 0; m_id = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_exp = '0;
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid && $urandom_range(2) == 0) begin
        req0_valid = 1'b1; req0_op = 5'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      end
      if (!req1_valid && $urandom_range(2) == 0) begin
        req1_valid = 1'b1; req1_op = 5'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      end
      resp_ready = $urandom_range(3) != 0;
      #1;
      pr0 = !m_fl && req0_valid && (!req1_valid || !m_ptr);
      pr1 = !m_fl && req1_valid && (!req0_valid || m_ptr);
      prv = m_fl && m_wait == 0;
      chk("rnd_ready0", 32'(d1_req0_ready), 32'(pr0));
      chk("rnd_ready1", 32'(d1_req1_ready), 32'(pr1));
      chk("rnd_busy", 32'(d1_busy), 32'(m_fl));
      chk("rnd_resp_valid", 32'(d1_resp_valid), 32'(prv));
      if (prv) chk("rnd_resp", 32'({d1_resp_id, d1_resp_flags, d1_resp_result}), 32'({m_id, m_exp}));
      if (m_fl) chk("rnd_alu_in", 32'({d1_alu_choice, d1_alu_a, d1_alu_b}), 32'({m_op, m_a, m_b}));
      @(posedge clk);
      if (pr0 || pr1) begin
        m_fl = 1'b1; m_wait = LAT; m_id = pr1; m_ptr = !pr1;
        m_op = pr1 ? req1_op : req0_op;
        m_a = pr1 ? req1_a : req0_a;
        m_b = pr1 ? req1_b : req0_b;
        m_exp = alu_f(m_op, m_a, m_b);
      end else if (m_fl && m_wait > 0) m_wait--;
      else if (prv && resp_ready) m_fl = 1'b0;
      #1;
      if (pr0) req0_valid = 1'b0;
      if (pr1) req1_valid = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
